axi4_burst_slv_sram: RTL and testbench

AXI4 full slave memory model with parametrised data width, depth and ID width. Supports FIXED and INCR bursts, narrow transfers and ID echo, with independent read and write channels that can run concurrently. It is the simulation and FPGA main-memory target behind the chip's memory port. Contents are preloaded by the bench through the internal array `ram`.

---
 rtl/axi4_burst_slv_sram.sv | 213 +++++++++++++++++++++
 tb/tb_axi4_burst_slv_sram.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi4_burst_slv_sram.sv
// AXI4 slave memory model: FIXED/INCR bursts, narrow transfers, ID echo, independent R/W channels.
// Optional macro AXI_SRAM_WRAP_EN enables WRAP bursts (burst code 2'b10); otherwise 2'b10 behaves as INCR.
`timescale 1ns/1ps
module axi4_burst_slv_sram #(
  parameter int unsigned DW  = 128,
  parameter int unsigned AW  = 14,
  parameter int unsigned IDW = 8
) (
  input  logic             CLK,
  input  logic             RSTn,
  input  logic [IDW-1:0]   MEM_AWID,
  input  logic [31:0]      MEM_AWADDR,
  input  logic [7:0]       MEM_AWLEN,
  input  logic [2:0]       MEM_AWSIZE,
  input  logic [1:0]       MEM_AWBURST,
  input  logic             MEM_AWVALID,
  output logic             MEM_AWREADY,
  input  logic [DW-1:0]    MEM_WDATA,
  input  logic [DW/8-1:0]  MEM_WSTRB,
  input  logic             MEM_WLAST,
  input  logic             MEM_WVALID,
  output logic             MEM_WREADY,
  output logic [IDW-1:0]   MEM_BID,
  output logic [1:0]       MEM_BRESP,
  output logic             MEM_BVALID,
  input  logic             MEM_BREADY,
  input  logic [IDW-1:0]   MEM_ARID,
  input  logic [31:0]      MEM_ARADDR,
  input  logic [7:0]       MEM_ARLEN,
  input  logic [2:0]       MEM_ARSIZE,
  input  logic [1:0]       MEM_ARBURST,
  input  logic             MEM_ARVALID,
  output logic             MEM_ARREADY,
  output logic [IDW-1:0]   MEM_RID,
  output logic [DW-1:0]    MEM_RDATA,
  output logic [1:0]       MEM_RRESP,
  output logic             MEM_RLAST,
  output logic             MEM_RVALID,
  input  logic             MEM_RREADY
);
  localparam int unsigned OB = $clog2(DW / 8);
  localparam int unsigned SW = DW / 8;

  typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_t;
  typedef enum logic       {R_IDLE, R_DATA}         r_state_t;

  logic [DW-1:0] ram [0:(2**AW)-1];

  w_state_t    w_state;
  logic [31:0] w_addr;
  logic [7:0]  w_len, w_cnt;
  logic [2:0]  w_size;
  logic [1:0]  w_burst;
  r_state_t    r_state;
  logic [31:0] r_addr;
  logic [7:0]  r_len, r_cnt;
  logic [2:0]  r_size;
  logic [1:0]  r_burst;
  logic [2:0]  aw_size_c, ar_size_c;
  logic        w_fire_c;
  logic        unused_wlast;

  function automatic logic [AW-1:0] word_idx(input logic [31:0] a);
    return a[AW+OB-1:OB];
  endfunction

  function automatic logic [2:0] clamp_size(input logic [2:0] s);
    return (s > 3'(OB)) ? 3'(OB) : s;
  endfunction

  // Address of the beat following 'a'; unaligned INCR starts align from beat 1 onward.
  function automatic logic [31:0] next_addr(input logic [31:0] a, input logic [2:0] sz,
                                            input logic [1:0] bt, input logic [7:0] ln);
    logic [31:0] step;
    logic [31:0] nxt;
`ifdef AXI_SRAM_WRAP_EN
    logic [31:0] bnd;
`else
    logic        unused_len;
`endif
    step = 32'd1 << sz;
    nxt  = (a & ~(step - 32'd1)) + step;
`ifdef AXI_SRAM_WRAP_EN
    bnd = (32'(ln) + 32'd1) << sz;
    if (bt == 2'b10 && (ln == 8'd1 || ln == 8'd3 || ln == 8'd7 || ln == 8'd15))
      nxt = (a & ~(bnd - 32'd1)) + ((a + step) & (bnd - 32'd1));
`else
    unused_len = ^ln;
`endif
    if (bt == 2'b00) nxt = a;
    return nxt;
  endfunction

  assign aw_size_c    = clamp_size(MEM_AWSIZE);
  assign ar_size_c    = clamp_size(MEM_ARSIZE);
  assign w_fire_c     = (w_state == W_DATA) && MEM_WVALID && MEM_WREADY;
  assign unused_wlast = MEM_WLAST;
  assign MEM_BRESP    = 2'b00;
  assign MEM_RRESP    = 2'b00;

  // Write channel: AW accept, len+1 data beats (WLAST ignored), single B response.
  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      w_state     <= W_IDLE;
      MEM_AWREADY <= 1'b0;
      MEM_WREADY  <= 1'b0;
      MEM_BVALID  <= 1'b0;
      MEM_BID     <= '0;
      w_addr      <= '0;
      w_len       <= '0;
      w_cnt       <= '0;
      w_size      <= '0;
      w_burst     <= '0;
    end else begin
      case (w_state)
        W_IDLE: begin
          if (!MEM_AWREADY) begin
            MEM_AWREADY <= 1'b1;
          end else if (MEM_AWVALID) begin
            MEM_AWREADY <= 1'b0;
            MEM_WREADY  <= 1'b1;
            MEM_BID     <= MEM_AWID;
            w_addr      <= MEM_AWADDR;
            w_len       <= MEM_AWLEN;
            w_size      <= aw_size_c;
            w_burst     <= MEM_AWBURST;
            w_cnt       <= '0;
            w_state     <= W_DATA;
          end
        end
        W_DATA: begin
          if (w_fire_c) begin
            w_addr <= next_addr(w_addr, w_size, w_burst, w_len);
            w_cnt  <= w_cnt + 8'd1;
            if (w_cnt == w_len) begin
              MEM_WREADY <= 1'b0;
              MEM_BVALID <= 1'b1;
              w_state    <= W_RESP;
            end
          end
        end
        W_RESP: begin
          if (MEM_BREADY) begin
            MEM_BVALID <= 1'b0;
            w_state    <= W_IDLE;
          end
        end
        default: w_state <= W_IDLE;
      endcase
    end
  end

  // Byte-lane write into the array; contents survive reset.
  always_ff @(posedge CLK) begin
    if (w_fire_c) begin
      for (int b = 0; b < int'(SW); b++) begin
        if (MEM_WSTRB[b]) ram[word_idx(w_addr)][8*b +: 8] <= MEM_WDATA[8*b +: 8];
      end
    end
  end

  // Read channel: RDATA register is loaded at AR accept and on every non-last R handshake.
  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      r_state     <= R_IDLE;
      MEM_ARREADY <= 1'b0;
      MEM_RVALID  <= 1'b0;
      MEM_RLAST   <= 1'b0;
      MEM_RID     <= '0;
      MEM_RDATA   <= '0;
      r_addr      <= '0;
      r_len       <= '0;
      r_cnt       <= '0;
      r_size      <= '0;
      r_burst     <= '0;
    end else begin
      case (r_state)
        R_IDLE: begin
          if (!MEM_ARREADY) begin
            MEM_ARREADY <= 1'b1;
          end else if (MEM_ARVALID) begin
            MEM_ARREADY <= 1'b0;
            MEM_RVALID  <= 1'b1;
            MEM_RID     <= MEM_ARID;
            MEM_RDATA   <= ram[word_idx(MEM_ARADDR)];
            MEM_RLAST   <= (MEM_ARLEN == 8'd0);
            r_addr      <= next_addr(MEM_ARADDR, ar_size_c, MEM_ARBURST, MEM_ARLEN);
            r_len       <= MEM_ARLEN;
            r_size      <= ar_size_c;
            r_burst     <= MEM_ARBURST;
            r_cnt       <= '0;
            r_state     <= R_DATA;
          end
        end
        R_DATA: begin
          if (MEM_RREADY) begin
            if (MEM_RLAST) begin
              MEM_RVALID  <= 1'b0;
              MEM_RLAST   <= 1'b0;
              MEM_ARREADY <= 1'b1;
              r_state     <= R_IDLE;
            end else begin
              MEM_RDATA <= ram[word_idx(r_addr)];
              MEM_RLAST <= ((r_cnt + 8'd1) == r_len);
              r_addr    <= next_addr(r_addr, r_size, r_burst, r_len);
              r_cnt     <= r_cnt + 8'd1;
            end
          end
        end
      endcase
    end
  end
endmodule

// File: tb/tb_axi4_burst_slv_sram.sv
// Directed bench for axi4_burst_slv_sram: a read-burst vector table plus hand sequences for
// writes, narrow strobes, RREADY stalls, concurrent R/W and mid-burst reset.
`timescale 1ns/1ps
module tb_axi4_burst_slv_sram;
  localparam int unsigned DW = 128;
  localparam int unsigned AW = 14;
  localparam int unsigned IDW = 8;
  localparam int TMO = 50;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [IDW-1:0] awid = '0, arid = '0;
  logic [31:0] awaddr = '0, araddr = '0;
  logic [7:0] awlen = '0, arlen = '0;
  logic [2:0] awsize = '0, arsize = '0;
  logic [1:0] awburst = '0, arburst = '0;
  logic awvalid = 1'b0, arvalid = 1'b0, wvalid = 1'b0, wlast = 1'b0, bready = 1'b0, rready = 1'b0;
  logic [DW-1:0] wdata = '0;
  logic [DW/8-1:0] wstrb = '0;
  logic awready, wready, bvalid, arready, rvalid, rlast;
  logic [IDW-1:0] bid, rid;
  logic [1:0] bresp, rresp;
  logic [DW-1:0] rdata;

  int tests = 0;
  int fails = 0;

  axi4_burst_slv_sram #(.DW(DW), .AW(AW), .IDW(IDW)) dut (
    .CLK(clk), .RSTn(rst_n),
    .MEM_AWID(awid), .MEM_AWADDR(awaddr), .MEM_AWLEN(awlen), .MEM_AWSIZE(awsize),
    .MEM_AWBURST(awburst), .MEM_AWVALID(awvalid), .MEM_AWREADY(awready),
    .MEM_WDATA(wdata), .MEM_WSTRB(wstrb), .MEM_WLAST(wlast), .MEM_WVALID(wvalid), .MEM_WREADY(wready),
    .MEM_BID(bid), .MEM_BRESP(bresp), .MEM_BVALID(bvalid), .MEM_BREADY(bready),
    .MEM_ARID(arid), .MEM_ARADDR(araddr), .MEM_ARLEN(arlen), .MEM_ARSIZE(arsize),
    .MEM_ARBURST(arburst), .MEM_ARVALID(arvalid), .MEM_ARREADY(arready),
    .MEM_RID(rid), .MEM_RDATA(rdata), .MEM_RRESP(rresp), .MEM_RLAST(rlast),
    .MEM_RVALID(rvalid), .MEM_RREADY(rready)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0]      addr;
    logic [7:0]       len;
    logic [2:0]       size;
    logic [1:0]       burst;
    logic [7:0]       id;
    logic [3:0][15:0] idx;
  } rd_vec_t;

  // Preload pattern: every 32-bit lane carries the word index with a lane tag.
  function automatic logic [DW-1:0] pat(input int i);
    logic [31:0] b;
    b = 32'(i);
    return {b ^ 32'hA000_0000, b ^ 32'hB000_0000, b ^ 32'hC000_0000, b ^ 32'hD000_0000};
  endfunction

  function automatic rd_vec_t mk(input logic [31:0] a, input logic [7:0] l, input logic [2:0] s,
                                 input logic [1:0] bt, input logic [7:0] id,
                                 input int i0, input int i1, input int i2, input int i3);
    rd_vec_t v;
    v.addr = a; v.len = l; v.size = s; v.burst = bt; v.id = id;
    v.idx[0] = 16'(i0); v.idx[1] = 16'(i1); v.idx[2] = 16'(i2); v.idx[3] = 16'(i3);
    return v;
  endfunction

  task automatic chk(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_ar(input logic [31:0] a, input logic [7:0] l, input logic [2:0] s,
                       input logic [1:0] bt, input logic [7:0] id);
    int t;
    araddr = a; arlen = l; arsize = s; arburst = bt; arid = id; arvalid = 1'b1;
    t = 0;
    while (!arready && t < TMO) begin tick(); t++; end
    chk("arready wait", DW'(arready), DW'(1));
    tick();
    arvalid = 1'b0;
  endtask

  task automatic do_aw(input logic [31:0] a, input logic [7:0] l, input logic [2:0] s,
                       input logic [1:0] bt, input logic [7:0] id);
    int t;
    awaddr = a; awlen = l; awsize = s; awburst = bt; awid = id; awvalid = 1'b1;
    t = 0;
    while (!awready && t < TMO) begin tick(); t++; end
    chk("awready wait", DW'(awready), DW'(1));
    tick();
    awvalid = 1'b0;
  endtask

  task automatic do_w(input logic [DW-1:0] d, input logic [DW/8-1:0] st, input logic lst);
    int t;
    wdata = d; wstrb = st; wlast = lst; wvalid = 1'b1;
    t = 0;
    while (!wready && t < TMO) begin tick(); t++; end
    chk("wready wait", DW'(wready), DW'(1));
    tick();
    wvalid = 1'b0;
  endtask

  task automatic b_accept(input logic [7:0] id);
    int t;
    t = 0;
    while (!bvalid && t < TMO) begin tick(); t++; end
    chk("bvalid wait", DW'(bvalid), DW'(1));
    chk("bid", DW'(bid), DW'(id));
    chk("bresp", DW'(bresp), DW'(0));
    bready = 1'b1;
    tick();
    bready = 1'b0;
  endtask

  // Single-beat INCR read with expected data.
  task automatic rd1(input string nm, input logic [31:0] a, input logic [7:0] id, input logic [DW-1:0] exp);
    do_ar(a, 8'd0, 3'd4, 2'b01, id);
    chk({nm, " rvalid"}, DW'(rvalid), DW'(1));
    chk({nm, " rdata"}, rdata, exp);
    chk({nm, " rid"}, DW'(rid), DW'(id));
    chk({nm, " rlast"}, DW'(rlast), DW'(1));
    rready = 1'b1;
    tick();
    rready = 1'b0;
    chk({nm, " rvalid end"}, DW'(rvalid), DW'(0));
  endtask

  rd_vec_t vecs [6];

  initial begin
    logic [DW-1:0] d, e, d0, d1;
    vecs[0] = mk(32'h40,    8'd3, 3'd4, 2'b01, 8'h11, 4, 5, 6, 7);
    vecs[1] = mk(32'h80,    8'd2, 3'd4, 2'b00, 8'h22, 8, 8, 8, 0);
`ifdef AXI_SRAM_WRAP_EN
    vecs[2] = mk(32'h30,    8'd3, 3'd4, 2'b10, 8'h33, 3, 0, 1, 2);
`else
    vecs[2] = mk(32'h30,    8'd3, 3'd4, 2'b10, 8'h33, 3, 4, 5, 6);
`endif
    vecs[3] = mk(32'h104,   8'd3, 3'd2, 2'b01, 8'h44, 16, 16, 16, 17);
    vecs[4] = mk(32'h3FFF0, 8'd1, 3'd7, 2'b01, 8'h55, 16383, 0, 0, 0);
    vecs[5] = mk(32'h47,    8'd1, 3'd4, 2'b11, 8'h66, 4, 5, 0, 0);

    for (int i = 0; i < (1 << AW); i++) dut.ram[i] = pat(i);

    // Reset values, then ready rise on the first edge after release.
    repeat (3) tick();
    chk("rst awready", DW'(awready), DW'(0));
    chk("rst wready", DW'(wready), DW'(0));
    chk("rst bvalid", DW'(bvalid), DW'(0));
    chk("rst arready", DW'(arready), DW'(0));
    chk("rst rvalid", DW'(rvalid), DW'(0));
    chk("rst rlast", DW'(rlast), DW'(0));
    chk("rst rdata", rdata, '0);
    chk("rst ids", DW'({bid, rid}), DW'(0));
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    chk("post-rst awready", DW'(awready), DW'(1));
    chk("post-rst arready", DW'(arready), DW'(1));

    // Table-driven read bursts with RREADY held high: beats must be back-to-back.
    foreach (vecs[i]) begin
      do_ar(vecs[i].addr, vecs[i].len, vecs[i].size, vecs[i].burst, vecs[i].id);
      rready = 1'b1;
      for (int k = 0; k <= int'(vecs[i].len); k++) begin
        chk($sformatf("v%0d b%0d rvalid", i, k), DW'(rvalid), DW'(1));
        chk($sformatf("v%0d b%0d rdata", i, k), rdata, pat(int'(vecs[i].idx[k])));
        chk($sformatf("v%0d b%0d rid", i, k), DW'(rid), DW'(vecs[i].id));
        chk($sformatf("v%0d b%0d rresp", i, k), DW'(rresp), DW'(0));
        chk($sformatf("v%0d b%0d rlast", i, k), DW'(rlast), DW'(k == int'(vecs[i].len)));
        tick();
      end
      rready = 1'b0;
      chk($sformatf("v%0d arready after", i), DW'(arready), DW'(1));
      chk($sformatf("v%0d rvalid after", i), DW'(rvalid), DW'(0));
    end

    // Single full-width write, B timing/ID echo, AW gap, read back.
    d = 128'h0123456789ABCDEF0123456789ABCDEF;
    do_aw(32'h40, 8'd0, 3'd4, 2'b01, 8'h05);
    chk("wr wready", DW'(wready), DW'(1));
    chk("wr awready low", DW'(awready), DW'(0));
    do_w(d, 16'hFFFF, 1'b1);
    chk("wr bvalid", DW'(bvalid), DW'(1));
    chk("wr wready low", DW'(wready), DW'(0));
    b_accept(8'h05);
    chk("wr bvalid drop", DW'(bvalid), DW'(0));
    chk("wr aw gap", DW'(awready), DW'(0));
    tick();
    chk("wr awready back", DW'(awready), DW'(1));
    rd1("wr rb", 32'h40, 8'h77, d);

    // Narrow write into bytes 4..7 of word 0x10.
    do_aw(32'h104, 8'd0, 3'd2, 2'b01, 8'h09);
    do_w(DW'(32'hDEADBEEF) << 32, 16'h00F0, 1'b1);
    b_accept(8'h09);
    e = pat(16);
    e[63:32] = 32'hDEADBEEF;
    rd1("narrow rb", 32'h100, 8'h0A, e);

    // RREADY stall: payload holds until the handshake.
    do_ar(32'h500, 8'd1, 3'd4, 2'b01, 8'h3C);
    for (int c = 0; c < 6; c++) begin
      rready = (c == 2 || c == 5);
      chk($sformatf("stall c%0d rvalid", c), DW'(rvalid), DW'(1));
      chk($sformatf("stall c%0d rdata", c), rdata, pat(16'h50 + (c >= 3 ? 1 : 0)));
      chk($sformatf("stall c%0d rlast", c), DW'(rlast), DW'(c >= 3));
      chk($sformatf("stall c%0d rid", c), DW'(rid), DW'(8'h3C));
      tick();
    end
    rready = 1'b0;
    chk("stall rvalid end", DW'(rvalid), DW'(0));

    // Concurrent AW+AR; read reload of word 0x20 coincides with its write -> old data.
    d0 = {4{32'h1111_2222}};
    d1 = {4{32'h3333_4444}};
    awaddr = 32'h200; awlen = 8'd1; awsize = 3'd4; awburst = 2'b01; awid = 8'h21; awvalid = 1'b1;
    araddr = 32'h1F0; arlen = 8'd1; arsize = 3'd4; arburst = 2'b01; arid = 8'h31; arvalid = 1'b1;
    begin
      int t;
      t = 0;
      while (!(awready && arready) && t < TMO) begin tick(); t++; end
      chk("conc ready wait", DW'(awready && arready), DW'(1));
    end
    tick();
    awvalid = 1'b0; arvalid = 1'b0;
    chk("conc wready", DW'(wready), DW'(1));
    chk("conc rvalid", DW'(rvalid), DW'(1));
    chk("conc beat0", rdata, pat(16'h1F));
    wdata = d0; wstrb = '1; wlast = 1'b0; wvalid = 1'b1; rready = 1'b1;
    tick();
    chk("conc old data", rdata, pat(16'h20));
    chk("conc rlast", DW'(rlast), DW'(1));
    wdata = d1; wlast = 1'b1;
    tick();
    wvalid = 1'b0; rready = 1'b0;
    chk("conc rvalid end", DW'(rvalid), DW'(0));
    chk("conc arready", DW'(arready), DW'(1));
    b_accept(8'h21);
    rd1("conc rb 0x210", 32'h210, 8'h32, d1);

    // Mid-burst reset: outputs clear asynchronously, array keeps written words.
    do_ar(32'h40, 8'd3, 3'd4, 2'b01, 8'h12);
    chk("mid rvalid", DW'(rvalid), DW'(1));
    #2 rst_n = 1'b0;
    #1;
    chk("async rvalid", DW'(rvalid), DW'(0));
    chk("async arready", DW'(arready), DW'(0));
    chk("async rdata", rdata, '0);
    chk("async rid", DW'(rid), DW'(0));
    @(negedge clk);
    rst_n = 1'b1;
    chk("release arready low", DW'(arready), DW'(0));
    tick();
    chk("release arready", DW'(arready), DW'(1));
    rd1("post-rst rb 0x200", 32'h200, 8'h13, d0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end
endmodule
